// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operation
// encodings, FSM state encoding and default widths.
package ex_muldiv_pkg;

    localparam int MD_DATA_W = 32;
    localparam int MD_CNT_W  = 6;

    // Decoded mul/div operation as presented by the ID/EX register.
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    // Iteration controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

endpackage

// File: rtl/ex_muldiv_if.sv
// Bundle between the pipeline (ID/EX outputs, hazard unit) and the
// multiply/divide unit. master = pipeline side, slave = the unit.
interface ex_muldiv_if
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W
);
    logic              op_valid;
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              hilo_rd;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              busy;
    logic              done;
    logic              md_stall;

    modport master (
        output op_valid, op, a, b, hilo_rd,
        input  hi, lo, busy, done, md_stall
    );

    modport slave (
        input  op_valid, op, a, b, hilo_rd,
        output hi, lo, busy, done, md_stall
    );
endinterface

// File: rtl/ex_muldiv_md_sign_fix.sv
// Final sign correction applied in the FIX cycle. The iteration datapath
// works on magnitudes only; this block turns the raw accumulator into the
// signed HI/LO values.
module md_sign_fix
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W
) (
    input  logic                  is_div,    // accumulator holds {rem, quot}
    input  logic                  neg_res,   // sign(a) ^ sign(b) for signed ops
    input  logic                  neg_rem,   // remainder follows sign of a
    input  logic                  div_zero,  // divisor was zero
    input  logic [2*DATA_W-1:0]   acc,
    output logic [DATA_W-1:0]     hi_fix,
    output logic [DATA_W-1:0]     lo_fix
);
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quot;
    logic [DATA_W-1:0]   rem;

    // Negate product, or quotient/remainder, as the operand signs require.
    always_comb begin
        prod   = neg_res ? -acc : acc;
        quot   = acc[DATA_W-1:0];
        rem    = acc[2*DATA_W-1:DATA_W];
        hi_fix = prod[2*DATA_W-1:DATA_W];
        lo_fix = prod[DATA_W-1:0];
        if (is_div) begin
            // Divide by zero keeps the all-ones quotient regardless of signs;
            // the remainder path already reproduces a.
            lo_fix = (neg_res && !div_zero) ? -quot : quot;
            hi_fix = neg_rem ? -rem : rem;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage. Owns HI/LO, runs
// MULT/MULTU by shift-add and DIV/DIVU by restoring division (one bit per
// cycle), handles MTHI/MTLO in one cycle, and stalls the front end while an
// operation is in flight.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W,
    parameter int CNT_W  = MD_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    ex_muldiv_if.slave   bus
);
    md_state_e             state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]     opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic                  is_div_q, is_div_d;
    logic                  neg_res_q, neg_res_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  div_zero_q, div_zero_d;
    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic                  done_q, done_d;

    logic                  op_signed;
    logic                  sign_a, sign_b;
    logic [DATA_W-1:0]     mag_a, mag_b;
    logic [DATA_W:0]       mul_sum;
    logic [DATA_W:0]       div_shift;
    logic [DATA_W:0]       div_diff;
    logic                  div_ok;
    logic [DATA_W-1:0]     div_rem;
    logic [DATA_W-1:0]     fix_hi, fix_lo;

    md_sign_fix #(.DATA_W(DATA_W)) u_sign_fix (
        .is_div   (is_div_q),
        .neg_res  (neg_res_q),
        .neg_rem  (neg_rem_q),
        .div_zero (div_zero_q),
        .acc      (acc_q),
        .hi_fix   (fix_hi),
        .lo_fix   (fix_lo)
    );

    // Operand magnitudes and one step of each iteration datapath.
    always_comb begin
        op_signed = (bus.op == MD_MULT) || (bus.op == MD_DIV);
        sign_a    = op_signed & bus.a[DATA_W-1];
        sign_b    = op_signed & bus.b[DATA_W-1];
        // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
        mag_a     = sign_a ? -bus.a : bus.a;
        mag_b     = sign_b ? -bus.b : bus.b;

        // Shift-add: upper half accumulates, multiplier bits leave from the bottom.
        mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                  + (acc_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});

        // Restoring step: partial remainder shifted left with next dividend bit.
        div_shift = acc_q[2*DATA_W-1:DATA_W-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ok    = (div_shift >= {1'b0, opnd_q});
        div_rem   = div_ok ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
    end

    // Next-state logic: accept ops in IDLE, iterate DATA_W times, one
    // extra cycle to leave the loop, then write HI/LO in FIX.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    case (bus.op)
                        MD_MULT, MD_MULTU: begin
                            state_d    = ST_MUL;
                            count_d    = '0;
                            opnd_d     = mag_a;
                            acc_d      = {{DATA_W{1'b0}}, mag_b};
                            is_div_d   = 1'b0;
                            neg_res_d  = sign_a ^ sign_b;
                            neg_rem_d  = 1'b0;
                            div_zero_d = 1'b0;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_d    = ST_DIV;
                            count_d    = '0;
                            opnd_d     = mag_b;
                            acc_d      = {{DATA_W{1'b0}}, mag_a};
                            is_div_d   = 1'b1;
                            neg_res_d  = sign_a ^ sign_b;
                            neg_rem_d  = sign_a;
                            div_zero_d = (bus.b == '0);
                        end
                        MD_MTHI: hi_d = bus.a;
                        MD_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (count_q == CNT_W'(DATA_W)) begin
                    state_d = ST_FIX;
                end else begin
                    acc_d   = {mul_sum, acc_q[DATA_W-1:1]};
                    count_d = count_q + 1'b1;
                end
            end
            ST_DIV: begin
                if (count_q == CNT_W'(DATA_W)) begin
                    state_d = ST_FIX;
                end else begin
                    acc_d   = {div_rem, acc_q[DATA_W-2:0], div_ok};
                    count_d = count_q + 1'b1;
                end
            end
            ST_FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    // Stall anything that needs HI/LO or the unit while it is busy.
    always_comb begin
        bus.hi       = hi_q;
        bus.lo       = lo_q;
        bus.done     = done_q;
        bus.busy     = (state_q != ST_IDLE);
        bus.md_stall = (state_q != ST_IDLE) & (bus.op_valid | bus.hilo_rd);
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: results are queued on issue and checked by
// a monitor whenever done pulses; stall/MTHI/MTLO/reset behaviour is checked
// inline.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_muldiv_if #(.DATA_W(32)) bus();

    ex_muldiv #(.DATA_W(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end else begin
            $display("ok   %s = %08h", name, act);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected actual=1 expected=0 hi=%08h lo=%08h", bus.hi, bus.lo);
            end else begin
                e = sb.pop_front();
                chk($sformatf("T%0d_hi", e.id), bus.hi, e.hi);
                chk($sformatf("T%0d_lo", e.id), bus.lo, e.lo);
                chk($sformatf("T%0d_done_cycle", e.id), 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic start_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                            output int e0);
        bus.op_valid = 1'b1;
        bus.op       = o;
        bus.a        = av;
        bus.b        = bv;
        @(posedge clk);
        #1;
        e0 = cyc;
        bus.op_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 100);
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout actual=1 expected=0");
        end
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ehi, input logic [31:0] elo, input int id);
        int e0;
        start_op(o, av, bv, e0);
        sb.push_back('{hi: ehi, lo: elo, cyc: e0 + 34, id: id});
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int bad_stall;
        int bad_hi;
        int n;

        bus.op_valid = 1'b0;
        bus.op       = 3'd0;
        bus.a        = '0;
        bus.b        = '0;
        bus.hilo_rd  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        bus.hilo_rd = 1'b1;
        #1;
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_stall", 32'(bus.md_stall), 32'h0);
        bus.hilo_rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Arithmetic vectors with hand-computed results
        run(MD_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 1);
        chk("T1_stall_after", 32'(bus.md_stall), 32'h0);
        run(MD_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 2);
        run(MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 3);
        run(MD_DIVU,  32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF, 4);
        run(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 5);
        run(MD_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 6);
        run(MD_MULTU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 7);

        // MULT 6 * -7 followed by MFHI/MFLO: stalled until busy drops
        start_op(MD_MULT, 32'd6, 32'hFFFF_FFF9, e0);
        sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFD6, cyc: e0 + 34, id: 8});
        bus.hilo_rd = 1'b1;
        bad_stall = 0;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (!bus.busy || n > 100) break;
            if (bus.md_stall !== 1'b1) bad_stall++;
        end
        chk("T8_stall_cycles", 32'(bad_stall), 32'h0);
        chk("T8_busy_cycles", 32'(n), 32'd35);
        chk("T8_stall_idle", 32'(bus.md_stall), 32'h0);
        chk("T8_rd_lo", bus.lo, 32'hFFFF_FFD6);
        bus.hilo_rd = 1'b0;

        // MTHI issued while a MULTU is running: held off, then overwrites hi only
        start_op(MD_MULTU, 32'd3, 32'd5, e0);
        sb.push_back('{hi: 32'h0, lo: 32'd15, cyc: e0 + 34, id: 9});
        bus.op_valid = 1'b1;
        bus.op       = MD_MTHI;
        bus.a        = 32'h0000_1234;
        bus.b        = 32'h0;
        bad_stall = 0;
        bad_hi    = 0;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (!bus.busy || n > 100) break;
            if (bus.md_stall !== 1'b1) bad_stall++;
            if (bus.hi !== 32'hFFFF_FFFF) bad_hi++;
        end
        chk("T9_mthi_stalled", 32'(bad_stall), 32'h0);
        chk("T9_hi_held", 32'(bad_hi), 32'h0);
        chk("T9_stall_idle", 32'(bus.md_stall), 32'h0);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        chk("T9_mthi_hi", bus.hi, 32'h0000_1234);
        chk("T9_mthi_lo", bus.lo, 32'd15);
        chk("T9_mthi_busy", 32'(bus.busy), 32'h0);

        // MTLO in IDLE: lo on next edge, no done pulse
        @(negedge clk);
        start_op(MD_MTLO, 32'h0000_CAFE, 32'h0, e0);
        chk("T10_mtlo_lo", bus.lo, 32'h0000_CAFE);
        chk("T10_mtlo_hi", bus.hi, 32'h0000_1234);
        chk("T10_mtlo_done", 32'(bus.done), 32'h0);
        @(negedge clk);
        chk("T10_mtlo_done2", 32'(bus.done), 32'h0);

        // Op code 6 is ignored
        start_op(3'd6, 32'hDEAD_BEEF, 32'h1, e0);
        chk("T11_op6_hi", bus.hi, 32'h0000_1234);
        chk("T11_op6_lo", bus.lo, 32'h0000_CAFE);
        chk("T11_op6_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);

        // Async reset in the middle of a DIVU
        start_op(MD_DIVU, 32'd100, 32'd7, e0);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("T12_rst_busy", 32'(bus.busy), 32'h0);
        chk("T12_rst_hi", bus.hi, 32'h0);
        chk("T12_rst_lo", bus.lo, 32'h0);
        chk("T12_rst_done", 32'(bus.done), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(MD_MULTU, 32'd3, 32'd4, 32'h0, 32'd12, 13);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
